tp_coord_reader: RTL and testbench

- Polls the capacitive touch IC through the shared byte-level I2C master and converts touch reports into `tp_x_coord`/`tp_y_coord` for the game controller's hit detection.
- Drives the release sentinel 0xFFFF on both coordinates when no finger is present. The sentinel lies outside every grid box, so no false hits occur.
- Sits between the I2C master and the game controller.

---
 rtl/tp_coord_reader.sv | 213 +++++++++++++++++++++
 tb/tb_tp_coord_reader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tp_coord_reader.sv
// rtl/tp_coord_reader.sv - Touch-panel coordinate poller over a byte-level I2C command port
//
// Purpose: periodically reads the touch controller status register. On a
// ready report with at least one point, it reads the first point (x_lo,
// x_hi, y_lo, y_hi), validates it and publishes it. The status register is
// then cleared with a write of 0. Repeated "zero point" reports release the
// coordinates to the 0xFFFF sentinel. Bus errors and response timeouts abort
// the sequence and bump a saturating error counter.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   enable                   permits new poll sequences to start
//   cmd_valid/cmd_ready      command handshake towards the I2C master
//   cmd_we/cmd_addr/cmd_wdata  command payload (1 = write)
//   rsp_valid/rsp_data/rsp_err single-cycle response from the I2C master
//   tp_x_coord/tp_y_coord    touch coordinates, 0xFFFF when released
//   touch_valid              coordinates hold a real touch
//   err_cnt                  saturating count of errors, timeouts, bad reports
module tp_coord_reader #(
  parameter int unsigned POLL_CYCLES = 500_000,
  parameter int unsigned RSP_TIMEOUT = 100_000,
  parameter int unsigned MISS_LIMIT  = 3,
  parameter int unsigned X_MAX       = 800,
  parameter int unsigned Y_MAX       = 480,
  parameter logic [15:0] STAT_ADDR   = 16'h814E,
  parameter logic [15:0] PT1_ADDR    = 16'h8150
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_we,
  output logic [15:0] cmd_addr,
  output logic [7:0]  cmd_wdata,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_data,
  input  logic        rsp_err,
  output logic [15:0] tp_x_coord,
  output logic [15:0] tp_y_coord,
  output logic        touch_valid,
  output logic [7:0]  err_cnt
);

  localparam int TW  = $clog2(POLL_CYCLES + 1);
  localparam int TMW = $clog2(RSP_TIMEOUT + 1);
  localparam int MW  = $clog2(MISS_LIMIT + 1);

  localparam logic [TW-1:0]  POLL_MAX = TW'(POLL_CYCLES);
  localparam logic [TMW-1:0] TMO_LAST = TMW'(RSP_TIMEOUT - 1);
  localparam logic [MW-1:0]  MISS_LIM = MW'(MISS_LIMIT);
  localparam logic [15:0]    X_LIM    = 16'(X_MAX);
  localparam logic [15:0]    Y_LIM    = 16'(Y_MAX);

  typedef enum logic [3:0] {
    IDLE, RD_STAT, WAIT_STAT, RD_XL, WAIT_XL, RD_XH, WAIT_XH,
    RD_YL, WAIT_YL, RD_YH, WAIT_YH, UPDATE, CLR, WAIT_CLR, ERR
  } state_t;

  state_t         state;
  logic [TW-1:0]  poll_timer;
  logic [TMW-1:0] tmo_cnt;
  logic [MW-1:0]  miss_cnt;
  logic [7:0]     x_lo, x_hi, y_lo, y_hi;

  logic [15:0]    x_word, y_word;
  logic [MW-1:0]  miss_inc;
  logic [7:0]     err_inc;

  assign x_word   = {x_hi, x_lo};
  assign y_word   = {y_hi, y_lo};
  assign miss_inc = (miss_cnt == MISS_LIM) ? miss_cnt : miss_cnt + MW'(1);
  assign err_inc  = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

  // Each issue state has a matching wait state entered on acceptance.
  function automatic state_t wait_of(input state_t s);
    case (s)
      RD_STAT: wait_of = WAIT_STAT;
      RD_XL:   wait_of = WAIT_XL;
      RD_XH:   wait_of = WAIT_XH;
      RD_YL:   wait_of = WAIT_YL;
      RD_YH:   wait_of = WAIT_YH;
      CLR:     wait_of = WAIT_CLR;
      default: wait_of = IDLE;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      poll_timer  <= '0;
      tmo_cnt     <= '0;
      miss_cnt    <= '0;
      x_lo        <= '0;
      x_hi        <= '0;
      y_lo        <= '0;
      y_hi        <= '0;
      cmd_valid   <= 1'b0;
      cmd_we      <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      tp_x_coord  <= 16'hFFFF;
      tp_y_coord  <= 16'hFFFF;
      touch_valid <= 1'b0;
      err_cnt     <= '0;
    end else begin
      if (poll_timer != POLL_MAX) poll_timer <= poll_timer + TW'(1);

      case (state)
        IDLE: begin
          if (enable && poll_timer == POLL_MAX) begin
            poll_timer <= '0;
            cmd_valid  <= 1'b1;
            cmd_we     <= 1'b0;
            cmd_addr   <= STAT_ADDR;
            cmd_wdata  <= 8'h00;
            state      <= RD_STAT;
          end
        end

        RD_STAT, RD_XL, RD_XH, RD_YL, RD_YH, CLR: begin
          // Payload stays put until the master takes it.
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            tmo_cnt   <= '0;
            state     <= wait_of(state);
          end
        end

        WAIT_STAT, WAIT_XL, WAIT_XH, WAIT_YL, WAIT_YH, WAIT_CLR: begin
          if (rsp_valid && rsp_err) begin
            state <= ERR;
          end else if (rsp_valid) begin
            case (state)
              WAIT_STAT: begin
                if (!rsp_data[7]) begin
                  state <= IDLE;
                end else if (rsp_data[3:0] == 4'd0) begin
                  miss_cnt <= miss_inc;
                  if (miss_inc == MISS_LIM) begin
                    tp_x_coord  <= 16'hFFFF;
                    tp_y_coord  <= 16'hFFFF;
                    touch_valid <= 1'b0;
                  end
                  cmd_valid <= 1'b1;
                  cmd_we    <= 1'b1;
                  cmd_addr  <= STAT_ADDR;
                  cmd_wdata <= 8'h00;
                  state     <= CLR;
                end else begin
                  cmd_valid <= 1'b1;
                  cmd_addr  <= PT1_ADDR;
                  state     <= RD_XL;
                end
              end
              WAIT_XL: begin
                x_lo      <= rsp_data;
                cmd_valid <= 1'b1;
                cmd_addr  <= PT1_ADDR + 16'd1;
                state     <= RD_XH;
              end
              WAIT_XH: begin
                x_hi      <= rsp_data;
                cmd_valid <= 1'b1;
                cmd_addr  <= PT1_ADDR + 16'd2;
                state     <= RD_YL;
              end
              WAIT_YL: begin
                y_lo      <= rsp_data;
                cmd_valid <= 1'b1;
                cmd_addr  <= PT1_ADDR + 16'd3;
                state     <= RD_YH;
              end
              WAIT_YH: begin
                y_hi  <= rsp_data;
                state <= UPDATE;
              end
              default: state <= IDLE;
            endcase
          end else if (tmo_cnt == TMO_LAST) begin
            state <= ERR;
          end else begin
            tmo_cnt <= tmo_cnt + TMW'(1);
          end
        end

        UPDATE: begin
          if (x_word < X_LIM && y_word < Y_LIM) begin
            tp_x_coord  <= x_word;
            tp_y_coord  <= y_word;
            touch_valid <= 1'b1;
            miss_cnt    <= '0;
          end else begin
            err_cnt <= err_inc;
          end
          cmd_valid <= 1'b1;
          cmd_we    <= 1'b1;
          cmd_addr  <= STAT_ADDR;
          cmd_wdata <= 8'h00;
          state     <= CLR;
        end

        ERR: begin
          err_cnt <= err_inc;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tp_coord_reader.sv
// tb/tb_tp_coord_reader.sv - Directed self-checking bench for tp_coord_reader
module tb_tp_coord_reader;

  localparam int POLL = 20;
  localparam int TMO  = 30;

  logic        clk = 1'b0;
  logic        rst, enable, cmd_valid, cmd_ready, cmd_we;
  logic        rsp_valid, rsp_err, touch_valid;
  logic [15:0] cmd_addr, tp_x_coord, tp_y_coord;
  logic [7:0]  cmd_wdata, rsp_data, err_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0]  stat_byte;
  logic [7:0]  pts [4];
  logic [15:0] err_addr, drop_addr;
  logic [15:0] log_addr [$];
  logic        log_we [$];
  logic [7:0]  log_wdata [$];
  int          log_cyc [$];
  logic [15:0] r_addr;
  logic        r_we;

  tp_coord_reader #(.POLL_CYCLES(POLL), .RSP_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .tp_x_coord(tp_x_coord), .tp_y_coord(tp_y_coord),
    .touch_valid(touch_valid), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [15:0] a);
    case (a)
      16'h814E: return stat_byte;
      16'h8150: return pts[0];
      16'h8151: return pts[1];
      16'h8152: return pts[2];
      16'h8153: return pts[3];
      default:  return 8'hEE;
    endcase
  endfunction

  // I2C master model: logs accepted commands, answers two cycles later.
  initial begin
    rsp_valid = 1'b0; rsp_data = 8'h00; rsp_err = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst && cmd_valid && cmd_ready) begin
        r_addr = cmd_addr;
        r_we   = cmd_we;
        log_addr.push_back(r_addr);
        log_we.push_back(r_we);
        log_wdata.push_back(cmd_wdata);
        log_cyc.push_back(cyc);
        if (r_addr != drop_addr) begin
          repeat (2) @(posedge clk);
          #1;
          rsp_valid = 1'b1;
          rsp_data  = r_we ? 8'h00 : rd_byte(r_addr);
          rsp_err   = (r_addr == err_addr);
          @(posedge clk);
          #1;
          rsp_valid = 1'b0;
          rsp_err   = 1'b0;
        end
      end
    end
  end

  task automatic clear_log();
    log_addr.delete(); log_we.delete(); log_wdata.delete(); log_cyc.delete();
  endtask

  // Runs exactly one poll sequence and lets it finish.
  task automatic one_poll(input string tag);
    int t;
    clear_log();
    @(negedge clk);
    enable = 1'b1;
    t = 0;
    while (log_addr.size() == 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    enable = 1'b0;
    chk({tag, "_start"}, log_addr.size() > 0, 1);
    repeat (80) @(negedge clk);
  endtask

  logic [15:0] exp_addr [6];
  logic [5:0]  we_bits;
  int          t, stable;

  initial begin
    rst = 1'b1; enable = 1'b0; cmd_ready = 1'b1;
    err_addr = 16'h0000; drop_addr = 16'h0000;
    stat_byte = 8'h81;
    pts = '{8'h20, 8'h01, 8'hC8, 8'h00};
    exp_addr = '{16'h814E, 16'h8150, 16'h8151, 16'h8152, 16'h8153, 16'h814E};

    repeat (3) @(negedge clk);
    chk("rst_x", tp_x_coord, 16'hFFFF);
    chk("rst_y", tp_y_coord, 16'hFFFF);
    chk("rst_touch", touch_valid, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_addr", cmd_addr, 0);
    chk("rst_err", err_cnt, 0);
    rst = 1'b0;

    // Full touch report: x = 0x0120, y = 0x00C8.
    one_poll("touch");
    chk("touch_x", tp_x_coord, 16'h0120);
    chk("touch_y", tp_y_coord, 16'h00C8);
    chk("touch_valid", touch_valid, 1);
    chk("touch_ncmd", log_addr.size(), 6);
    we_bits = '0;
    for (int i = 0; i < 6 && i < log_addr.size(); i++) begin
      chk($sformatf("touch_addr%0d", i), log_addr[i], exp_addr[i]);
      we_bits[i] = log_we[i];
    end
    chk("touch_we", we_bits, 6'b100000);
    chk("touch_clr_data", (log_wdata.size() == 6) ? log_wdata[5] : 8'hEE, 8'h00);

    // Three zero-point reports release on the third.
    stat_byte = 8'h80;
    one_poll("miss1");
    chk("miss1_valid", touch_valid, 1);
    chk("miss1_x", tp_x_coord, 16'h0120);
    chk("miss1_ncmd", log_addr.size(), 2);
    one_poll("miss2");
    chk("miss2_valid", touch_valid, 1);
    one_poll("miss3");
    chk("miss3_x", tp_x_coord, 16'hFFFF);
    chk("miss3_y", tp_y_coord, 16'hFFFF);
    chk("miss3_valid", touch_valid, 0);

    // A new touch clears the miss count, so a single miss keeps it.
    stat_byte = 8'h81;
    one_poll("retouch");
    chk("retouch_x", tp_x_coord, 16'h0120);
    chk("retouch_valid", touch_valid, 1);
    stat_byte = 8'h80;
    one_poll("miss_after_touch");
    chk("miss_after_touch_valid", touch_valid, 1);

    // Buffer not ready: status read only, nothing changes.
    stat_byte = 8'h00;
    one_poll("notready");
    chk("notready_ncmd", log_addr.size(), 1);
    chk("notready_x", tp_x_coord, 16'h0120);
    chk("notready_valid", touch_valid, 1);
    chk("notready_err", err_cnt, 0);

    // Start spacing: timer runs 0..POLL inclusive, so starts are POLL+1 apart.
    clear_log();
    @(negedge clk);
    enable = 1'b1;
    t = 0;
    while (log_addr.size() < 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    enable = 1'b0;
    chk("period_ncmd", log_addr.size() >= 2, 1);
    chk("period", (log_cyc.size() >= 2) ? log_cyc[1] - log_cyc[0] : -1, POLL + 1);
    repeat (80) @(negedge clk);

    // x = 0x0384 = 900 is out of range.
    stat_byte = 8'h81;
    pts = '{8'h84, 8'h03, 8'hC8, 8'h00};
    one_poll("badx");
    chk("badx_x", tp_x_coord, 16'h0120);
    chk("badx_y", tp_y_coord, 16'h00C8);
    chk("badx_err", err_cnt, 1);
    chk("badx_ncmd", log_addr.size(), 6);
    chk("badx_clr_we", (log_we.size() == 6) ? log_we[5] : 1'b0, 1);

    // Bus error on the y_lo read.
    pts = '{8'h10, 8'h00, 8'h20, 8'h00};
    err_addr = 16'h8152;
    one_poll("rsperr");
    chk("rsperr_err", err_cnt, 2);
    chk("rsperr_ncmd", log_addr.size(), 4);
    chk("rsperr_x", tp_x_coord, 16'h0120);
    chk("rsperr_valid", touch_valid, 1);
    err_addr = 16'h0000;

    // No response to the x_hi read.
    drop_addr = 16'h8151;
    one_poll("tmo");
    chk("tmo_err", err_cnt, 3);
    chk("tmo_ncmd", log_addr.size(), 3);
    chk("tmo_y", tp_y_coord, 16'h00C8);
    drop_addr = 16'h0000;

    // Many errors saturate the counter.
    err_addr = 16'h814E;
    @(negedge clk);
    enable = 1'b1;
    repeat (300 * (POLL + 2)) @(negedge clk);
    enable = 1'b0;
    repeat (80) @(negedge clk);
    chk("sat_err", err_cnt, 8'hFF);
    chk("sat_x", tp_x_coord, 16'h0120);
    err_addr = 16'h0000;

    // Stalled master: payload must hold steady.
    pts = '{8'h20, 8'h01, 8'hC8, 8'h00};
    cmd_ready = 1'b0;
    clear_log();
    @(negedge clk);
    enable = 1'b1;
    t = 0;
    while (!cmd_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    enable = 1'b0;
    chk("stall_start", cmd_valid, 1);
    stable = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_valid && cmd_addr == 16'h814E && !cmd_we) stable++;
    end
    chk("stall_stable", stable, 50);
    chk("stall_noaccept", log_addr.size(), 0);
    cmd_ready = 1'b1;

    // Reset while waiting on x_hi, then a stale response arrives.
    t = 0;
    while (log_addr.size() < 3 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("xh_reached", log_addr.size(), 3);
    rst = 1'b1;
    #1;
    chk("arst_x", tp_x_coord, 16'hFFFF);
    chk("arst_y", tp_y_coord, 16'hFFFF);
    chk("arst_touch", touch_valid, 0);
    chk("arst_cmd_valid", cmd_valid, 0);
    chk("arst_err", err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("stale_cmd_valid", cmd_valid, 0);
    chk("stale_ncmd", log_addr.size(), 3);
    chk("stale_x", tp_x_coord, 16'hFFFF);
    chk("stale_touch", touch_valid, 0);
    chk("stale_err", err_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
